// File: rtl/i2s_rx_ctrl.sv
// I2S master receiver for a mono MEMS mic: divides aclk into bclk/wclk, captures the
// right-slot sample MSB-first and hands it out as a stream beat. Optional overrun_cnt via I2S_RX_OVERRUN_CNT_EN.
module i2s_rx_ctrl #(
  parameter int BCLK_DIV    = 4,
  parameter int SLOT_BITS   = 32,
  parameter int SAMPLE_BITS = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   enable,
  output logic                   bclk,
  output logic                   wclk,
  input  logic                   d_audio,
  output logic                   m_tvalid,
  output logic [SAMPLE_BITS-1:0] m_tdata,
  input  logic                   m_tready,
  output logic                   overrun,
  output logic                   busy
`ifdef I2S_RX_OVERRUN_CNT_EN
  ,
  output logic [7:0]             overrun_cnt
`endif
);

  localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = (SLOT_BITS > 2) ? $clog2(SLOT_BITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(BCLK_DIV / 2);
  localparam logic [BIT_W-1:0] SLOT_LAST = BIT_W'(SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] LSB_BIT   = BIT_W'(SAMPLE_BITS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [DIV_W-1:0]        div_cnt;
  logic [DIV_W-1:0]        div_inc;
  logic [BIT_W-1:0]        bit_cnt;
  logic [SAMPLE_BITS-1:0]  shift_reg;
  logic                    done_q;
  logic                    div_last;
  logic                    slot_last;
  logic                    fall_evt;
  logic                    start;
  logic                    cap_bit;
  logic                    lsb_evt;
  logic                    drop;

  assign div_inc   = div_cnt + 1'b1;
  assign div_last  = (div_cnt == DIV_LAST);
  assign slot_last = (bit_cnt == SLOT_LAST);
  assign start     = (state == ST_IDLE) && enable;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Stopping is only allowed at the end of the right slot so the bus idles on a frame boundary.
  always_comb begin
    state_next = state;
    fall_evt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) state_next = ST_RUN;
      end
      ST_RUN: begin
        fall_evt = div_last;
        if (!enable) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        fall_evt = div_last;
        if (enable) begin
          state_next = ST_RUN;
        end else if (div_last && !wclk && slot_last) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // bclk is registered from the divider value that becomes current at the same edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (start || (state_next == ST_IDLE)) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (div_last) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else begin
      div_cnt <= div_inc;
      bclk    <= (div_inc >= DIV_HALF);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bit_cnt <= '0;
      wclk    <= 1'b1;
    end else if (start) begin
      bit_cnt <= '0;
      wclk    <= 1'b1;
    end else if (fall_evt) begin
      if (slot_last) begin
        bit_cnt <= '0;
        wclk    <= ~wclk;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Slot bit 0 is the one-bclk I2S delay; the sample occupies bits 1..SAMPLE_BITS.
  assign cap_bit = fall_evt && !wclk && (bit_cnt != '0) && (bit_cnt <= LSB_BIT);
  assign lsb_evt = fall_evt && !wclk && (bit_cnt == LSB_BIT);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      shift_reg <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= lsb_evt;
      if (start) begin
        shift_reg <= '0;
      end else if (cap_bit) begin
        shift_reg <= {shift_reg[SAMPLE_BITS-2:0], d_audio};
      end
    end
  end

  assign drop = done_q && m_tvalid && !m_tready;

  // A completing sample may replace a beat that is being accepted in the same cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
    end else if (done_q && (!m_tvalid || m_tready)) begin
      m_tvalid <= 1'b1;
      m_tdata  <= shift_reg;
    end else if (m_tvalid && m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      overrun <= 1'b0;
    end else if (start) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end
  end

`ifdef I2S_RX_OVERRUN_CNT_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      overrun_cnt <= '0;
    end else if (start) begin
      overrun_cnt <= '0;
    end else if (drop && (overrun_cnt != 8'hFF)) begin
      overrun_cnt <= overrun_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// Bench for i2s_rx_ctrl: an I2S mic model feeds random or fixed words and a
// transaction-level model of the output channel predicts every beat.
module tb_i2s_rx_ctrl;

  localparam int BCLK_DIV    = 4;
  localparam int SLOT_BITS   = 32;
  localparam int SAMPLE_BITS = 16;
  localparam int HALF_FRAME  = BCLK_DIV * SLOT_BITS;
  localparam int FRAME       = 2 * HALF_FRAME;
  localparam int FIRST_BEAT  = 1 + HALF_FRAME + BCLK_DIV * (SAMPLE_BITS + 1) + 1;
  localparam int SEL_BCLK = 0, SEL_WCLK = 1, SEL_TVALID = 2, SEL_BUSY = 3;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic enable = 1'b0;
  logic d_audio;
  logic m_tready = 1'b1;
  logic bclk, wclk, m_tvalid, overrun, busy;
  logic [SAMPLE_BITS-1:0] m_tdata;
`ifdef I2S_RX_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt;
`endif

  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;

  logic mic_fixed_en = 1'b0;
  logic [SAMPLE_BITS-1:0] mic_fixed = '0;
  logic [SAMPLE_BITS-1:0] mic_word = '0;
  logic [SAMPLE_BITS-1:0] last_word = '0;
  int mic_j = 99;
  logic mic_prev_w = 1'b1;
  int comp_seq = 0;
  int clr_seq = 0;

  logic mv = 1'b0;
  logic [SAMPLE_BITS-1:0] md = '0;
  logic ovr = 1'b0;
  int ocnt = 0;
  int comp_seen = 0;
  int clr_seen = 0;
  logic mdl_acc;

  i2s_rx_ctrl #(
    .BCLK_DIV(BCLK_DIV),
    .SLOT_BITS(SLOT_BITS),
    .SAMPLE_BITS(SAMPLE_BITS)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .enable(enable),
    .bclk(bclk),
    .wclk(wclk),
    .d_audio(d_audio),
    .m_tvalid(m_tvalid),
    .m_tdata(m_tdata),
    .m_tready(m_tready),
    .overrun(overrun),
    .busy(busy)
`ifdef I2S_RX_OVERRUN_CNT_EN
    ,
    .overrun_cnt(overrun_cnt)
`endif
  );

  always #5 aclk = ~aclk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic rdy);
    enable   = en;
    m_tready = rdy;
  endtask

  task automatic waitFor(input string tag, input int sel, input logic lvl, input int max_cyc, output int n);
    logic s;
    n = 0;
    forever begin
      case (sel)
        SEL_BCLK:   s = bclk;
        SEL_WCLK:   s = wclk;
        SEL_TVALID: s = m_tvalid;
        default:    s = busy;
      endcase
      if (s === lvl) break;
      if (n >= max_cyc) begin
        total++;
        bad++;
        $error("[TB] FAIL %s timeout observed=%b expected=%b", tag, s, lvl);
        break;
      end
      @(posedge aclk);
      #1;
      n++;
    end
  endtask

  // Mic: drives bit i of the word after bclk fall i+1 of the right slot, counting the fall that moves wclk low as fall 0.
  initial begin
    d_audio = 1'b0;
    forever begin
      @(negedge bclk);
      #1;
      if (!wclk) begin
        if (mic_prev_w) begin
          mic_j    = 0;
          mic_word = mic_fixed_en ? mic_fixed : SAMPLE_BITS'($urandom);
        end else begin
          mic_j++;
        end
      end
      mic_prev_w = wclk;
      if (!wclk && mic_j >= 1 && mic_j <= SAMPLE_BITS) d_audio = mic_word[SAMPLE_BITS - mic_j];
      else d_audio = 1'($urandom_range(0, 1));
      if (!wclk && mic_j == SAMPLE_BITS + 1) begin
        last_word = mic_word;
        comp_seq++;
      end
    end
  end

  // Output-channel model: a completed word shows up one cycle later unless a beat is stuck.
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mv = 1'b0;
      md = '0;
      ovr = 1'b0;
      ocnt = 0;
      comp_seen = comp_seq;
      clr_seen = clr_seq;
    end else begin
      if (clr_seen != clr_seq) begin
        clr_seen = clr_seq;
        ovr = 1'b0;
        ocnt = 0;
      end
      mdl_acc = mv && m_tready;
      if (comp_seen != comp_seq) begin
        comp_seen = comp_seq;
        if (!mv || mdl_acc) begin
          mv = 1'b1;
          md = last_word;
        end else begin
          ovr = 1'b1;
          if (ocnt < 255) ocnt++;
        end
      end else if (mdl_acc) begin
        mv = 1'b0;
      end
    end
  end

  always @(negedge aclk) begin
    if (chk_en && aresetn) begin
      checkOutput("cyc_tvalid", 32'(m_tvalid), 32'(mv));
      checkOutput("cyc_tdata", 32'(m_tdata), 32'(md));
      checkOutput("cyc_overrun", 32'(overrun), 32'(ovr));
`ifdef I2S_RX_OVERRUN_CNT_EN
      checkOutput("cyc_overrun_cnt", 32'(overrun_cnt), 32'(ocnt));
`endif
    end
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, n_hi, n_lo, ones;
    logic [SAMPLE_BITS-1:0] held;

    applyStimulus(1'b0, 1'b1);
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("rst_bclk", 32'(bclk), 32'd0);
    checkOutput("rst_wclk", 32'(wclk), 32'd1);
    checkOutput("rst_tvalid", 32'(m_tvalid), 32'd0);
    checkOutput("rst_tdata", 32'(m_tdata), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    aresetn = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("idle_busy", 32'(busy), 32'd0);
    chk_en = 1'b1;

    $display("[TB] fixed pattern A5C3, ready high");
    mic_fixed_en = 1'b1;
    mic_fixed = 16'hA5C3;
    applyStimulus(1'b1, 1'b1);
    clr_seq++;
    waitFor("first_bclk", SEL_BCLK, 1'b1, 20, n);
    checkOutput("first_bclk_delay", 32'(n), 32'(1 + BCLK_DIV / 2));
    waitFor("bclk_fall", SEL_BCLK, 1'b0, 20, n_hi);
    waitFor("bclk_rise", SEL_BCLK, 1'b1, 20, n_lo);
    checkOutput("bclk_high", 32'(n_hi), 32'(BCLK_DIV / 2));
    checkOutput("bclk_period", 32'(n_hi + n_lo), 32'(BCLK_DIV));
    waitFor("wclk_fall", SEL_WCLK, 1'b0, 300, n);
    waitFor("wclk_rise", SEL_WCLK, 1'b1, 300, n);
    checkOutput("wclk_half_frame", 32'(n), 32'(HALF_FRAME));
    waitFor("beat_a", SEL_TVALID, 1'b1, 400, n);
    checkOutput("beat_a5c3", 32'(m_tdata), 32'h0000A5C3);
    @(posedge aclk);
    #1;
    checkOutput("tvalid_one_cycle", 32'(m_tvalid), 32'd0);
    waitFor("beat_b", SEL_TVALID, 1'b1, 400, n);
    checkOutput("beat_interval", 32'(n + 1), 32'(FRAME));
    checkOutput("no_overrun", 32'(overrun), 32'd0);
    @(posedge aclk);
    #1;

    $display("[TB] backpressure across two frames");
    mic_fixed_en = 1'b0;
    applyStimulus(1'b1, 1'b0);
    waitFor("held_beat", SEL_TVALID, 1'b1, 400, n);
    held = last_word;
    checkOutput("held_first", 32'(m_tdata), 32'(held));
    repeat (2 * FRAME + 20) @(posedge aclk);
    #1;
    checkOutput("held_valid", 32'(m_tvalid), 32'd1);
    checkOutput("held_data", 32'(m_tdata), 32'(held));
    checkOutput("overrun_set", 32'(overrun), 32'd1);
    applyStimulus(1'b1, 1'b1);
    @(posedge aclk);
    #1;
    checkOutput("held_transferred", 32'(m_tvalid), 32'd0);
    applyStimulus(1'b0, 1'b1);
    waitFor("drain_idle", SEL_BUSY, 1'b0, 700, n);
    checkOutput("overrun_sticky", 32'(overrun), 32'd1);
    applyStimulus(1'b1, 1'b1);
    clr_seq++;
    @(posedge aclk);
    #1;
    checkOutput("overrun_cleared", 32'(overrun), 32'd0);

    $display("[TB] stop in the middle of the right slot");
    waitFor("r_slot", SEL_WCLK, 1'b0, 300, n);
    repeat (40) @(posedge aclk);
    #1;
    applyStimulus(1'b0, 1'b1);
    waitFor("drain_beat", SEL_TVALID, 1'b1, 100, n);
    checkOutput("drain_beat_data", 32'(m_tdata), 32'(last_word));
    waitFor("stop_idle", SEL_BUSY, 1'b0, 200, n);
    checkOutput("idle_wclk", 32'(wclk), 32'd1);
    checkOutput("idle_bclk", 32'(bclk), 32'd0);
    ones = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge aclk);
      #1;
      if (bclk !== 1'b0 || busy !== 1'b0) ones++;
    end
    checkOutput("quiet_after_idle", 32'(ones), 32'd0);

    $display("[TB] drain cancelled in the left slot");
    applyStimulus(1'b1, 1'b1);
    clr_seq++;
    waitFor("l_fall", SEL_WCLK, 1'b0, 300, n);
    waitFor("l_rise", SEL_WCLK, 1'b1, 300, n);
    repeat (20) @(posedge aclk);
    #1;
    applyStimulus(1'b0, 1'b1);
    repeat (20) @(posedge aclk);
    #1;
    checkOutput("drain_busy", 32'(busy), 32'd1);
    applyStimulus(1'b1, 1'b1);
    waitFor("resume_beat", SEL_TVALID, 1'b1, 400, n);
    checkOutput("resume_latency", 32'(n), 32'(FIRST_BEAT - 1 - 40));
    checkOutput("resume_data", 32'(m_tdata), 32'(last_word));

    $display("[TB] reset during the 10th captured bit");
    waitFor("p_rise", SEL_WCLK, 1'b1, 300, n);
    waitFor("p_fall", SEL_WCLK, 1'b0, 300, n);
    repeat (BCLK_DIV * 11 - 2) @(posedge aclk);
    #1;
    aresetn = 1'b0;
    applyStimulus(1'b0, 1'b1);
    #1;
    checkOutput("mid_rst_bclk", 32'(bclk), 32'd0);
    checkOutput("mid_rst_wclk", 32'(wclk), 32'd1);
    checkOutput("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
    checkOutput("mid_rst_tdata", 32'(m_tdata), 32'd0);
    checkOutput("mid_rst_overrun", 32'(overrun), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    applyStimulus(1'b1, 1'b1);
    clr_seq++;
    waitFor("post_rst_beat", SEL_TVALID, 1'b1, 400, n);
    checkOutput("first_beat_latency", 32'(n), 32'(FIRST_BEAT));
    checkOutput("post_rst_data", 32'(m_tdata), 32'(last_word));

    $display("[TB] completion and late acceptance in the same cycle");
    @(posedge aclk);
    #1;
    applyStimulus(1'b1, 1'b0);
    waitFor("simul_a", SEL_TVALID, 1'b1, 400, n);
    held = last_word;
    repeat (FRAME - 1) @(posedge aclk);
    #1;
    checkOutput("simul_held", 32'(m_tdata), 32'(held));
    applyStimulus(1'b1, 1'b1);
    @(posedge aclk);
    #1;
    checkOutput("simul_valid", 32'(m_tvalid), 32'd1);
    checkOutput("simul_data", 32'(m_tdata), 32'(last_word));
    checkOutput("simul_no_overrun", 32'(overrun), 32'd0);
    @(posedge aclk);
    #1;
    checkOutput("simul_b_accepted", 32'(m_tvalid), 32'd0);
    waitFor("b2b_beat", SEL_TVALID, 1'b1, 400, n);
    checkOutput("b2b_data", 32'(m_tdata), 32'(last_word));

`ifdef I2S_RX_OVERRUN_CNT_EN
    $display("[TB] overrun counter saturation");
    @(posedge aclk);
    #1;
    applyStimulus(1'b1, 1'b0);
    repeat (270 * FRAME) @(posedge aclk);
    #1;
    checkOutput("cnt_saturated", 32'(overrun_cnt), 32'd255);
    checkOutput("cnt_overrun", 32'(overrun), 32'd1);
    applyStimulus(1'b1, 1'b1);
`endif

    applyStimulus(1'b0, 1'b1);
    waitFor("final_idle", SEL_BUSY, 1'b0, 700, n);
    checkOutput("final_wclk", 32'(wclk), 32'd1);
    repeat (4) @(posedge aclk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_rx_ctrl.md
Name: i2s_rx_ctrl

Overview:
- I2S master-side controller for the mono MEMS microphone path.
- Generates bclk/wclk from the system clock and captures the right-channel sample MSB-first.
- Presents each sample to the MFCC front end as an AXI-Stream-style beat with backpressure.
- Sequences clean start/stop on whole-frame boundaries and flags overruns.

Parameters:
- BCLK_DIV, 4: aclk cycles per bclk period; even, >=4.
- SLOT_BITS, 32: bclk periods per half-frame (per wclk level); >= SAMPLE_BITS+1.
- SAMPLE_BITS, 16: captured bits per sample.

Ports:
- aclk  in  1  system clock; all logic on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- enable  in  1  level; 1 = run the mic interface.
- bclk  out  1  I2S bit clock, registered.
- wclk  out  1  I2S word select, registered; 0 = right (captured), 1 = left (ignored).
- d_audio  in  1  serial data from mic, already synchronised to aclk.
- m_tvalid  out  1  sample valid.
- m_tdata  out  SAMPLE_BITS  signed sample.
- m_tready  in  1  downstream accept.
- overrun  out  1  sticky: a sample was dropped.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: bclk=0, wclk=1, m_tvalid=0, m_tdata=0, overrun=0, busy=0. State=IDLE; all counters 0.
- Reset asserted mid-operation: immediate return to reset values; any partial sample is discarded.
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN when enable=1. The first bclk rise occurs BCLK_DIV/2 cycles later.
  - RUN -> DRAIN when enable=0.
  - DRAIN -> RUN if enable=1 again before the drain completes.
  - DRAIN -> IDLE at the fall event where wclk goes 0->1, i.e. the end of the right slot. In that cycle wclk=1 and bclk=0.
- Clock divider:
  - div_cnt runs 0..BCLK_DIV-1 while state != IDLE.
  - bclk=1 for div_cnt in [BCLK_DIV/2, BCLK_DIV-1], else 0.
  - Fall event = the aclk cycle in which bclk goes 1->0. All capture and wclk actions happen only on fall events.
- Word clock:
  - bit_cnt runs 0..SLOT_BITS-1 and advances on each fall event.
  - At bit_cnt==SLOT_BITS-1, wclk toggles and bit_cnt wraps to 0.
  - RUN always starts in the left slot (wclk=1, bit_cnt=0).
- Capture (right slot only, wclk=0):
  - d_audio is shifted in MSB-first on fall events with bit_cnt 1..SAMPLE_BITS (one-bclk I2S delay).
  - Slot bits beyond SAMPLE_BITS are ignored.
  - The left slot is never captured.
- Output handshake:
  - m_tvalid rises the aclk cycle after the LSB fall event, with m_tdata = assembled sample.
  - A beat transfers when m_tvalid & m_tready. m_tvalid drops the next cycle; m_tdata holds its last value.
  - m_tdata and m_tvalid stay stable while m_tvalid=1 and m_tready=0.
- Overrun:
  - Condition: a new sample completes while the previous one is still unaccepted.
  - The new sample is dropped, the old sample is kept, and overrun is set.
  - overrun is sticky and clears only on IDLE->RUN or reset.
- Simultaneous completion and acceptance in the same cycle: the old sample transfers, the new sample loads, m_tvalid stays 1, no overrun.
- In DRAIN, a sample already in progress completes and is delivered normally. A pending beat survives IDLE until accepted.
- Sample rate = aclk / (BCLK_DIV * 2 * SLOT_BITS); 256 aclk per frame at defaults.

Optional Feature:
- Macro: I2S_RX_OVERRUN_CNT_EN.
- Defined:
  - Adds output overrun_cnt, 8 bits, reset 0.
  - Increments once per dropped sample and saturates at 255.
  - Clears on IDLE->RUN.
  - The overrun flag behaves as without the macro.
- Undefined: the port and its logic are absent; there is no other behaviour change.

Test Plan:
- Reset, then enable=1 with defaults and d_audio driven from pattern 16'hA5C3 in the right slot, m_tready=1 -> bclk period 4 aclk; wclk toggles every 128 aclk; m_tdata=16'hA5C3 with a 1-cycle m_tvalid every 256 aclk; overrun=0.
- m_tready=0 across two frames -> the first sample is held stable, the second is dropped, overrun=1. Then m_tready=1 -> the first sample transfers. A second IDLE->RUN clears overrun.
- enable=0 in the middle of the right slot -> the current sample is still delivered, then IDLE with bclk=0, wclk=1, busy=0. No further fall events occur.
- aresetn pulsed low during the 10th captured bit -> all outputs return to reset values at once. After re-enable the next sample is correct and the partial sample is never output.
- Completion and acceptance forced into the same cycle with m_tready asserted late -> no overrun; back-to-back beats carry the correct values.
- With I2S_RX_OVERRUN_CNT_EN defined and m_tready=0 for 300 frames -> overrun_cnt saturates at 255.
